// File: rtl/smi_self_link_unpacker.sv
// Wide-to-narrow SELF link stage: one packed multi-flit word in, one flit per cycle out.
// Optional direct input-to-output load is enabled by defining SMI_SELF_LINK_UNPACK_BYPASS_EN.
module smi_self_link_unpacker #(
    parameter int FlitWidth     = 64,
    parameter int FlitCountLog2 = 2
) (
    input  logic                                       clk,
    input  logic                                       srst,
    input  logic [FlitWidth*(2**FlitCountLog2)-1:0]    dataIn,
    input  logic [FlitCountLog2-1:0]                   dataInLen,
    input  logic                                       dataInValid,
    output logic                                       dataInStop,
    output logic [FlitWidth-1:0]                       dataOut,
    output logic                                       dataOutLast,
    output logic                                       dataOutValid,
    input  logic                                       dataOutStop
);

    localparam int FlitCount = 2 ** FlitCountLog2;
    localparam int WordWidth = FlitWidth * FlitCount;

    // SELF handshake: a word moves across a boundary on a cycle where valid is high
    // and stop is low; both stop outputs here come straight from flops.

    logic                     hold_full_q, hold_full_d;
    logic [WordWidth-1:0]     hold_data_q, hold_data_d;
    logic [FlitCountLog2-1:0] hold_len_q,  hold_len_d;

    logic                     out_valid_q, out_valid_d;
    logic [WordWidth-1:0]     out_data_q,  out_data_d;
    logic [FlitCountLog2-1:0] out_len_q,   out_len_d;
    logic [FlitCountLog2-1:0] idx_q,       idx_d;

    // Equals holdFull OR the one-cycle post-reset stop, kept as a single flop.
    logic                     in_stop_q,   in_stop_d;

    logic                     in_xfer;
    logic                     out_xfer;
    logic                     out_last;
    logic                     out_free;
    logic                     bypass_load;
    logic [FlitWidth-1:0]     out_flits [FlitCount];

    assign in_xfer  = dataInValid && !in_stop_q;
    assign out_last = out_valid_q && (idx_q == out_len_q);
    assign out_xfer = out_valid_q && !dataOutStop;
    assign out_free = !out_valid_q || (out_xfer && out_last);

`ifdef SMI_SELF_LINK_UNPACK_BYPASS_EN
    assign bypass_load = out_free && !hold_full_q && in_xfer;
`else
    assign bypass_load = 1'b0;
`endif

    always_comb begin
        for (int k = 0; k < FlitCount; k++) begin
            out_flits[k] = out_data_q[k*FlitWidth +: FlitWidth];
        end
    end

    assign dataOut      = out_flits[idx_q];
    assign dataOutLast  = out_last;
    assign dataOutValid = out_valid_q;
    assign dataInStop   = in_stop_q;

    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_len_d  = hold_len_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        idx_d       = idx_q;

        if (out_xfer && !out_last) begin
            idx_d = idx_q + FlitCountLog2'(1);
        end

        // Hold always drains first so word order is preserved.
        if (out_free && hold_full_q) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_data_q;
            out_len_d   = hold_len_q;
            idx_d       = '0;
            hold_full_d = 1'b0;
        end else if (bypass_load) begin
            out_valid_d = 1'b1;
            out_data_d  = dataIn;
            out_len_d   = dataInLen;
            idx_d       = '0;
        end else begin
            if (in_xfer) begin
                hold_full_d = 1'b1;
                hold_data_d = dataIn;
                hold_len_d  = dataInLen;
            end
            if (out_free) begin
                out_valid_d = 1'b0;
            end
        end

        in_stop_d = hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            hold_full_q <= 1'b0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            in_stop_q   <= 1'b1;
        end else begin
            hold_full_q <= hold_full_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            in_stop_q   <= in_stop_d;
        end
    end

    // Payload registers carry no reset; they are qualified by the valid/full flags.
    always_ff @(posedge clk) begin
        hold_data_q <= hold_data_d;
        hold_len_q  <= hold_len_d;
        out_data_q  <= out_data_d;
        out_len_q   <= out_len_d;
    end

endmodule

// File: tb/tb_smi_self_link_unpacker.sv
// Directed bench for smi_self_link_unpacker; expectations follow the build's
// SMI_SELF_LINK_UNPACK_BYPASS_EN setting (latency 1 with bypass, 2 without).
module tb_smi_self_link_unpacker;

    localparam int FW = 64;
    localparam int WW = 256;
`ifdef SMI_SELF_LINK_UNPACK_BYPASS_EN
    localparam int B2bSpan = 7;
`else
    localparam int B2bSpan = 14;
`endif

    logic          clk = 1'b0;
    logic          srst;
    logic [WW-1:0] dataIn;
    logic [1:0]    dataInLen;
    logic          dataInValid;
    logic          dataInStop;
    logic [FW-1:0] dataOut;
    logic          dataOutLast;
    logic          dataOutValid;
    logic          dataOutStop;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int flit_cnt = 0;
    int last_cnt = 0;
    int out_cyc[$];
    logic [64:0] exp_q[$];
    logic [64:0] mon_exp;
    logic [64:0] prev_out;
    logic        stalled_prev = 1'b0;
    logic        done;
    int mark, fc0, lc0, n;
    logic [WW-1:0] w1, w2, w3, w4, w5, wm;
    logic [1:0]    mix_len [4];

    smi_self_link_unpacker #(.FlitWidth(64), .FlitCountLog2(2)) dut (
        .clk         (clk),
        .srst        (srst),
        .dataIn      (dataIn),
        .dataInLen   (dataInLen),
        .dataInValid (dataInValid),
        .dataInStop  (dataInStop),
        .dataOut     (dataOut),
        .dataOutLast (dataOutLast),
        .dataOutValid(dataOutValid),
        .dataOutStop (dataOutStop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        vectors++;
        errors++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] flit(input logic [WW-1:0] w, input int k);
        return w[k*FW +: FW];
    endfunction

    task automatic push_word(input logic [WW-1:0] w, input logic [1:0] len);
        for (int k = 0; k <= int'(len); k++) begin
            exp_q.push_back({(k == int'(len)), flit(w, k)});
        end
    endtask

    task automatic send(input logic [WW-1:0] w, input logic [1:0] len);
        int t = 0;
        dataIn      = w;
        dataInLen   = len;
        dataInValid = 1'b1;
        while (dataInStop && t < 100) begin
            tick();
            t++;
        end
        if (dataInStop) begin
            fail_timeout("send_accept");
        end else begin
            push_word(w, len);
            tick();
        end
        dataInValid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || dataOutValid) && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) fail_timeout("drain");
        check("drain_empty", 65'(exp_q.size()), 65'(0));
    endtask

    task automatic wait_flit(input logic [FW-1:0] f, input string tag);
        int t = 0;
        while (!(dataOutValid === 1'b1 && dataOut === f) && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) fail_timeout(tag);
    endtask

    // Output monitor: checks every accepted flit in order and stability under stop.
    always @(negedge clk) begin
        if (stalled_prev && !srst) begin
            check("stall_valid", 65'(dataOutValid), 65'(1));
            check("stall_data", {dataOutLast, dataOut}, prev_out);
        end
        if (dataOutValid === 1'b1 && dataOutStop === 1'b0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $error("FAIL unexpected_flit: observed %0h expected none", dataOut);
            end else begin
                mon_exp = exp_q.pop_front();
                check("flit", {dataOutLast, dataOut}, mon_exp);
            end
            flit_cnt++;
            if (dataOutLast) last_cnt++;
            out_cyc.push_back(cyc);
        end
        stalled_prev = (dataOutValid === 1'b1) && (dataOutStop === 1'b1);
        prev_out = {dataOutLast, dataOut};
    end

    initial begin
        #200000;
        $error("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        w1 = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
              64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        w2 = {64'h2222_0000_0000_0003, 64'h2222_0000_0000_0002,
              64'h2222_0000_0000_0001, 64'h2222_0000_0000_0000};
        w3 = {128'h0, 64'h3333_0000_0000_0001, 64'h3333_0000_0000_0000};
        w4 = {64'h4444_0000_0000_0003, 64'h4444_0000_0000_0002,
              64'h4444_0000_0000_0001, 64'h4444_0000_0000_0000};
        w5 = {128'h0, 64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
        mix_len[0] = 2'd0;
        mix_len[1] = 2'd2;
        mix_len[2] = 2'd1;
        mix_len[3] = 2'd3;

        // Reset release with a 4-flit word already offered.
        srst        = 1'b1;
        dataIn      = w1;
        dataInLen   = 2'd3;
        dataInValid = 1'b1;
        dataOutStop = 1'b0;
        tick(); tick(); tick();
        check("rst_out_valid", 65'(dataOutValid), 65'(0));
        check("rst_out_last", 65'(dataOutLast), 65'(0));
        check("rst_in_stop", 65'(dataInStop), 65'(1));
        srst = 1'b0;
        check("release_stop_hi", 65'(dataInStop), 65'(1));
        tick();
        check("release_stop_lo", 65'(dataInStop), 65'(0));
        check("release_out_valid", 65'(dataOutValid), 65'(0));
        push_word(w1, 2'd3);
        tick();
        dataInValid = 1'b0;
`ifndef SMI_SELF_LINK_UNPACK_BYPASS_EN
        check("hold_path_valid", 65'(dataOutValid), 65'(0));
        check("hold_path_stop", 65'(dataInStop), 65'(1));
        tick();
        check("hold_drained_stop", 65'(dataInStop), 65'(0));
`endif
        for (int k = 0; k < 4; k++) begin
            check("w1_valid", 65'(dataOutValid), 65'(1));
            check("w1_data", 65'(dataOut), 65'(flit(w1, k)));
            check("w1_last", 65'(dataOutLast), 65'(k == 3));
            tick();
        end
        check("w1_after_valid", 65'(dataOutValid), 65'(0));
        drain();

        // Back-to-back 1-flit words.
        mark = out_cyc.size();
        for (int i = 0; i < 8; i++) send(WW'(i), 2'd0);
        drain();
        check("b2b_count", 65'(out_cyc.size() - mark), 65'(8));
        if (out_cyc.size() - mark == 8) begin
            check("b2b_span", 65'(out_cyc[mark+7] - out_cyc[mark]), 65'(B2bSpan));
        end

        // Backpressure during flit 1 with a second word offered.
        send(w2, 2'd3);
        wait_flit(flit(w2, 1), "bp_wait_flit1");
        dataOutStop = 1'b1;
        dataIn      = w3;
        dataInLen   = 2'd1;
        dataInValid = 1'b1;
        check("bp_hold_empty", 65'(dataInStop), 65'(0));
        push_word(w3, 2'd1);
        tick();
        dataInValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_in_stop", 65'(dataInStop), 65'(1));
            check("bp_flit1", 65'(dataOut), 65'(flit(w2, 1)));
            check("bp_last", 65'(dataOutLast), 65'(0));
            tick();
        end
        dataOutStop = 1'b0;
        drain();

        // Mixed lengths under random downstream stop.
        fc0  = flit_cnt;
        lc0  = last_cnt;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    wm = {4{64'h6000_0000_0000_0000 | 64'(i * 16)}} +
                         {64'd3, 64'd2, 64'd1, 64'd0};
                    send(wm, mix_len[i]);
                end
                drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    dataOutStop = ($urandom_range(0, 99) < 30);
                    tick();
                end
                dataOutStop = 1'b0;
            end
        join
        check("mix_flits", 65'(flit_cnt - fc0), 65'(10));
        check("mix_lasts", 65'(last_cnt - lc0), 65'(4));

        // Reset while flit 1 of a 4-flit word is being accepted.
        lc0 = last_cnt;
        send(w4, 2'd3);
        wait_flit(flit(w4, 1), "rst_wait_flit1");
        srst = 1'b1;
        tick();
        exp_q.delete();
        check("midrst_valid", 65'(dataOutValid), 65'(0));
        check("midrst_last", 65'(dataOutLast), 65'(0));
        check("midrst_stop", 65'(dataInStop), 65'(1));
        check("midrst_no_last", 65'(last_cnt), 65'(lc0));
        srst = 1'b0;
        send(w5, 2'd1);
        n = 0;
        while (dataOutValid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) fail_timeout("midrst_next_word");
        check("midrst_next_flit0", 65'(dataOut), 65'(flit(w5, 0)));
        check("midrst_next_last", 65'(dataOutLast), 65'(0));
        drain();
        check("midrst_lasts", 65'(last_cnt - lc0), 65'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/smi_self_link_unpacker.md
# smi_self_link_unpacker

Wide-to-narrow SELF link stage. Accepts packed multi-flit words with a flit count and emits them one flit per cycle, with a last-flit marker. It sits directly downstream of the SMI double buffer on wide frame paths and feeds the narrow flit network. All control outputs are registered, so there is no combinatorial path from `dataOutStop` to `dataInStop`.

## Interface
- `FlitWidth`, 64: width of one output flit in bits.
- `FlitCountLog2`, 2: log2 of flits per input word. FlitCount = 2**FlitCountLog2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `srst`  in  1  reset, synchronous, active-high.
- `dataIn`  in  FlitWidth*FlitCount  packed word. Flit k = `dataIn[k*FlitWidth +: FlitWidth]`.
- `dataInLen`  in  FlitCountLog2  number of valid flits minus 1 (0 means 1 flit).
- `dataInValid`  in  1  upstream SELF valid.
- `dataInStop`  out  1  upstream SELF stop; registered.
- `dataOut`  out  FlitWidth  current flit.
- `dataOutLast`  out  1  high on the final flit of a word.
- `dataOutValid`  out  1  downstream SELF valid; registered.
- `dataOutStop`  in  1  downstream SELF stop.

## Operation
- Transfer rule:
  - Input transfer: `dataInValid && !dataInStop`.
  - Output transfer: `dataOutValid && !dataOutStop`.
  - Data and length are captured only on a transfer.
- Hold stage: holds one word (`holdFull`, data, len). `dataInStop = holdFull || rstStop`.
- Output stage: holds one word (`outValid`, data, len, index `idx`).
  - `dataOut` = flit `idx`.
  - `dataOutLast = outValid && (idx == len)`.
  - `dataOutValid = outValid`.
- `outFree` = `!outValid` or (output transfer with `dataOutLast`).
- Each cycle, evaluated in priority order:
  1. Output transfer, not last: `idx` increments by 1. No wrap is needed because `idx` never exceeds `len`.
  2. If `outFree` and `holdFull`: load output from hold, `idx`=0, clear `holdFull`.
  3. If `outFree`, hold empty, and input transfer (bypass, see Configuration): load output directly from input, `idx`=0.
  4. Otherwise, input transfer: load hold, set `holdFull`.
  5. If `outFree` and nothing loads: `outValid`=0.
- Hold cannot be both loaded and drained in one cycle, because input transfer requires `!holdFull`.
- Word order is preserved. Flits within a word are emitted in ascending index order.
- `dataOutValid` stays high and `dataOut`/`dataOutLast` stay stable while `dataOutStop` is high.
- Reset:
  - During `srst`: `holdFull`=0, `outValid`=0, `idx`=0, `rstStop`=1.
  - First cycle after `srst` deasserts: `rstStop` clears.
  - `dataInStop` is therefore 1 during reset and for 1 cycle after.
  - Data registers are not reset. `dataOut` is undefined while `dataOutValid`=0.
- Reset mid-word: partially emitted flits are discarded. No `dataOutLast` is produced for the aborted word.

## Timing
- Reset values: `dataOutValid`=0, `dataOutLast`=0, `dataInStop`=1.
- Latency, bypass path: input transfer at cycle t gives flit 0 valid at t+1.
- Latency, hold path: input transfer at t gives flit 0 valid at t+2 at the earliest.
- Throughput: 1 flit/cycle sustained for any mix of lengths with bypass. The next word's flit 0 follows a last flit with no bubble.
- `dataInStop` rises the cycle after a word enters hold. It falls the cycle after hold drains.

## Configuration
- Macro: `SMI_SELF_LINK_UNPACK_BYPASS_EN`.
- Defined: step 3 is active (direct input-to-output load, latency 1).
- Undefined: step 3 is removed. Every word passes through hold.
  - Latency is 2.
  - 1-flit words sustain only 1 word per 2 cycles.
  - Words of 2 or more flits still sustain 1 flit/cycle.
- Ordering and handshake rules are identical in both builds.

## Test plan
- Reset release: hold `srst` 3 cycles, `dataInValid`=1 throughout -> `dataInStop`=1 in the cycle after release and 0 in the next, `dataOutValid`=0 until the first accept.
- Single 4-flit word: `dataIn`={D,C,B,A}, `dataInLen`=3, `dataOutStop`=0 -> A,B,C,D on 4 consecutive cycles, `dataOutLast` only with D. With bypass, A appears 1 cycle after accept.
- Back-to-back 1-flit words: 8 words, values 0..7, `dataOutStop`=0 -> with bypass, 8 consecutive output cycles. Without bypass, output every second cycle and `dataInStop` toggles.
- Backpressure: `dataOutStop`=1 for 5 cycles mid-word (during flit 1 of a `dataInLen`=3 word), next word offered -> flit 1 held stable, second word captured in hold, `dataInStop`=1, no data loss or reorder after the stop is released.
- Mixed lengths: stream lengths 1,3,2,4 with random `dataOutStop` at 30% -> scoreboard matches 10 flits in order, with exactly 4 `dataOutLast` pulses.
- Reset mid-word: assert `srst` after flit 1 of a 4-flit word -> `dataOutValid`=0 next cycle, remaining flits never emitted, next word output starts at flit 0.
